apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Two-requester APB master sequencer/arbiter. Grants the shared APB bus round-robin,
//  runs the IDLE->SETUP->ACCESS sequence, drives per-slave selects (GPIO=1, UART=2),
//  and returns read data, a done pulse and an error flag to the winning requester.
//  Sits between requesters (testbench/CPU port, DMA-style agent) and the slave PREADY/PRDATA mux.
// PARAMETERS
//  ADDR_W   5    APB address width
//  DATA_W   32   APB data width
//  TIMEOUT  16   max ACCESS wait cycles before abort (>=2)
// PORTS
//  PCLK        in   1       bus clock, rising edge
//  PRESETn     in   1       asynchronous active-low reset
//  reqN        in   1       N=0,1: request; held with selN/writeN/addrN/wdataN until doneN
//  selN        in   2       target: 1=GPIO, 2=UART, 0/3=invalid
//  writeN      in   1       1=write, 0=read
//  addrN       in   ADDR_W  target address
//  wdataN      in   DATA_W  write data
//  doneN       out  1       one-cycle completion pulse
//  errN        out  1       valid with doneN: 1=invalid sel or timeout
//  rdataN      out  DATA_W  read data, valid with doneN, held until next doneN
//  PSEL1       out  1       GPIO select
//  PSEL2       out  1       UART select
//  PENABLE     out  1       ACCESS phase
//  PWRITE      out  1       direction
//  PADDR       out  ADDR_W  address
//  PWDATA      out  DATA_W  write data
//  PREADY      in   1       selected slave ready (externally muxed)
//  PRDATA      in   DATA_W  selected slave read data (externally muxed)
//  state       out  2       00 IDLE, 01 SETUP, 10 ACCESS, 11 ERR
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, state IDLE, priority ptr -> requester 0, wait cnt 0.
//  - Arbitration in IDLE, and at ACCESS/ERR completion edge: eligible = reqN; requester just
//    completed is masked that edge. Both eligible -> ptr winner; ptr flips to loser after each grant.
//  - Winner sel valid -> SETUP: PADDR/PWRITE/PWDATA registered from winner; PSEL1|PSEL2 per sel;
//    PENABLE=0. Exactly one cycle, then ACCESS.
//  - ACCESS: PENABLE=1, PSEL held. Each edge with PREADY=1 completes: capture PRDATA into
//    rdataN (reads only; writes leave rdataN unchanged), doneN=1 next cycle, errN=0.
//  - Completion: other requester eligible -> SETUP directly (no IDLE); else IDLE, PSEL/PENABLE=0.
//  - Wait cnt increments each ACCESS cycle with PREADY=0; at TIMEOUT: abort, PSEL/PENABLE=0,
//    doneN=1,errN=1,rdataN=0 next cycle; next state as completion.
//  - Invalid sel winner -> ERR for one cycle, no PSEL/PENABLE; on exit doneN=1,errN=1,rdataN unchanged.
//  - Min latency req->doneN: 3 cycles (IDLE sample, SETUP, ACCESS w/ PREADY), done in 4th.
//  - PADDR/PWRITE/PWDATA hold last values in IDLE. Never both PSEL1 and PSEL2.
//  - reqN dropped before doneN: undefined for requester; arbiter still completes the APB transfer.
//  - Reset mid-transfer: bus aborted immediately, no doneN issued after release.
// TESTING
//  1. req0 sel=1 write addr=5'h04 wdata=32'hA5, PREADY=1 -> SETUP PSEL1=1 PENABLE=0, ACCESS
//     PENABLE=1, done0 1 cycle err0=0, state 01,10,00.
//  2. req0,req1 together after reset, PREADY=1 -> req0 served, ACCESS->SETUP straight to req1;
//     repeat both together -> req1 first.
//  3. req1 sel=2 read, PREADY low 3 cycles, PRDATA=32'hDEADBEEF -> ACCESS 4 cycles,
//     rdata1=32'hDEADBEEF with done1, err1=0.
//  4. req0 read, PREADY stuck 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, done0=1 err0=1 rdata0=0.
//  5. req1 sel=0 -> state 11 one cycle, PSEL1=PSEL2=0, done1=1 err1=1.
//  6. PRESETn low during ACCESS -> all outputs 0 immediately, state 00; no done after release.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester APB master sequencer with round-robin arbitration.
// Grants the shared bus, runs IDLE->SETUP->ACCESS, drives GPIO/UART selects and
// returns done/err/rdata to whichever requester owned the finished transfer.
module apb_req_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic [1:0]        sel0,
  input  logic              write0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [1:0]        sel1,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  output logic [1:0]        state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_ERR    = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;     // requester favoured on a tie
  logic                cur_q, cur_d;     // owner of the transfer in flight
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                psel1_d, psel2_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic                done0_d, done1_d, err0_d, err1_d;
  logic [DATA_W-1:0]   rdata0_d, rdata1_d;

  // Arbitration signals
  logic                elig0, elig1, grant, win;
  logic [1:0]          win_sel;
  logic                win_write;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  assign state = state_q;

  // Round-robin pick; the requester that just finished sits out this edge.
  always_comb begin
    elig0     = req0 & ~((state_q != ST_IDLE) & ~cur_q);
    elig1     = req1 & ~((state_q != ST_IDLE) &  cur_q);
    grant     = elig0 | elig1;
    win       = (elig0 & elig1) ? ptr_q : elig1;
    win_sel   = win ? sel1   : sel0;
    win_write = win ? write1 : write0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // Next-state and registered-output logic for the bus sequencer.
  always_comb begin
    logic finish, fin_err, fin_zero, arb;
    // NOTE: every variable gets a default up front so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    wait_d    = wait_q;
    psel1_d   = PSEL1;
    psel2_d   = PSEL2;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = err0;
    err1_d    = err1;
    rdata0_d  = rdata0;
    rdata1_d  = rdata1;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_zero  = 1'b0;
    arb       = 1'b0;

    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          finish = 1'b1;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          finish   = 1'b1;
          fin_err  = 1'b1;
          fin_zero = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_ERR: begin
        finish  = 1'b1;
        fin_err = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Report the finished transfer to its owner; read data only on a good read.
    if (finish) begin
      arb = 1'b1;
      if (!cur_q) begin
        done0_d = 1'b1;
        err0_d  = fin_err;
        if (fin_zero)              rdata0_d = '0;
        else if (!fin_err && !PWRITE) rdata0_d = PRDATA;
      end else begin
        done1_d = 1'b1;
        err1_d  = fin_err;
        if (fin_zero)              rdata1_d = '0;
        else if (!fin_err && !PWRITE) rdata1_d = PRDATA;
      end
    end

    // Launch the next transfer, or park the bus in IDLE.
    if (arb) begin
      penable_d = 1'b0;
      if (grant) begin
        cur_d = win;
        if (elig0 & elig1) ptr_d = ~win;
        if (win_sel == 2'd1 || win_sel == 2'd2) begin
          state_d  = ST_SETUP;
          psel1_d  = (win_sel == 2'd1);
          psel2_d  = (win_sel == 2'd2);
          pwrite_d = win_write;
          paddr_d  = win_addr;
          pwdata_d = win_wdata;
        end else begin
          state_d = ST_ERR;
          psel1_d = 1'b0;
          psel2_d = 1'b0;
        end
      end else begin
        state_d = ST_IDLE;
        psel1_d = 1'b0;
        psel2_d = 1'b0;
      end
    end
  end

  // State and output registers; async reset aborts any transfer immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: rdata registers are plain flops, not memory, so clearing them on reset is free
      // and gives the all-outputs-zero reset state.
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      cur_q   <= 1'b0;
      wait_q  <= '0;
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      wait_q  <= wait_d;
      PSEL1   <= psel1_d;
      PSEL2   <= psel2_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      done0   <= done0_d;
      done1   <= done1_d;
      err0    <= err0_d;
      err1    <= err1_d;
      rdata0  <= rdata0_d;
      rdata1  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_apb_req_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 2 * (2 + DATA_W) + 4 + ADDR_W + DATA_W + 2;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              req0, write0, req1, write1;
  logic [1:0]        sel0, sel1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, err0, done1, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              PSEL1, PSEL2, PENABLE, PWRITE, PREADY;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic [1:0]        state;
  logic [OUT_W-1:0]  all_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  assign all_out = {done0, err0, rdata0, done1, err1, rdata1,
                    PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, state};

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .sel0(sel0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .sel1(sel1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .state(state)
  );

  task automatic apply_reset;
    @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %h, want 0", all_out);
    end
  endtask

  task automatic test_write;
    PREADY = 1'b1;
    req0 = 1'b1; sel0 = 2'd1; write0 = 1'b1; addr0 = 5'h04; wdata0 = 32'hA5;
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !==
        {2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'h04, 32'hA5}) begin
      n_bad++;
      $display("FAIL write_setup: got st=%b s1=%b s2=%b en=%b wr=%b a=%h d=%h, want 01 1 0 0 1 04 a5",
               state, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL1, PENABLE, done0} !== {2'b10, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL write_access: got st=%b s1=%b en=%b done0=%b, want 10 1 1 0",
               state, PSEL1, PENABLE, done0);
    end
    @(negedge PCLK);
    n_cmp++;
    if ({done0, err0, state, PSEL1, PENABLE} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL write_done: got done0=%b err0=%b st=%b s1=%b en=%b, want 1 0 00 0 0",
               done0, err0, state, PSEL1, PENABLE);
    end
    req0 = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if ({done0, state, PADDR, PWDATA} !== {1'b0, 2'b00, 5'h04, 32'hA5}) begin
      n_bad++;
      $display("FAIL write_pulse_hold: got done0=%b st=%b a=%h d=%h, want 0 00 04 a5",
               done0, state, PADDR, PWDATA);
    end
  endtask

  task automatic test_round_robin;
    apply_reset;
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    req0 = 1'b1; sel0 = 2'd1; write0 = 1'b1; addr0 = 5'h0A; wdata0 = 32'h11;
    req1 = 1'b1; sel1 = 2'd2; write1 = 1'b0; addr1 = 5'h13; wdata1 = 32'h0;
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL1, PSEL2, PADDR} !== {2'b01, 1'b1, 1'b0, 5'h0A}) begin
      n_bad++;
      $display("FAIL rr1_first_req0: got st=%b s1=%b s2=%b a=%h, want 01 1 0 0a",
               state, PSEL1, PSEL2, PADDR);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({done0, done1, state, PSEL1, PSEL2, PENABLE} !== {1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rr1_handover: got d0=%b d1=%b st=%b s1=%b s2=%b en=%b, want 1 0 01 0 1 0",
               done0, done1, state, PSEL1, PSEL2, PENABLE);
    end
    req0 = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL2, PENABLE, PWRITE, PADDR} !== {2'b10, 1'b1, 1'b1, 1'b0, 5'h13}) begin
      n_bad++;
      $display("FAIL rr1_req1_access: got st=%b s2=%b en=%b wr=%b a=%h, want 10 1 1 0 13",
               state, PSEL2, PENABLE, PWRITE, PADDR);
    end
    @(negedge PCLK);
    n_cmp++;
    if ({done1, err1, rdata1, state} !== {1'b1, 1'b0, 32'h1234_5678, 2'b00}) begin
      n_bad++;
      $display("FAIL rr1_req1_done: got d1=%b e1=%b rd=%h st=%b, want 1 0 12345678 00",
               done1, err1, rdata1, state);
    end
    req1 = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if ({done1, state} !== {1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL rr1_idle: got d1=%b st=%b, want 0 00", done1, state);
    end
    // Second contested round: requester 1 now has priority.
    req0 = 1'b1; sel0 = 2'd1; write0 = 1'b0; addr0 = 5'h01;
    req1 = 1'b1; sel1 = 2'd2; write1 = 1'b1; addr1 = 5'h02; wdata1 = 32'h22;
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL1, PSEL2, PWRITE, PADDR} !== {2'b01, 1'b0, 1'b1, 1'b1, 5'h02}) begin
      n_bad++;
      $display("FAIL rr2_first_req1: got st=%b s1=%b s2=%b wr=%b a=%h, want 01 0 1 1 02",
               state, PSEL1, PSEL2, PWRITE, PADDR);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({done1, done0, state, PSEL1, PSEL2} !== {1'b1, 1'b0, 2'b01, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rr2_handover: got d1=%b d0=%b st=%b s1=%b s2=%b, want 1 0 01 1 0",
               done1, done0, state, PSEL1, PSEL2);
    end
    req1 = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({done0, err0, rdata0, state} !== {1'b1, 1'b0, 32'h1234_5678, 2'b00}) begin
      n_bad++;
      $display("FAIL rr2_req0_done: got d0=%b e0=%b rd=%h st=%b, want 1 0 12345678 00",
               done0, err0, rdata0, state);
    end
    req0 = 1'b0;
  endtask

  task automatic test_read_wait;
    int acc = 0;
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    req1 = 1'b1; sel1 = 2'd2; write1 = 1'b0; addr1 = 5'h1F;
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (state == 2'b10 && PENABLE && PSEL2) acc++;
      if (i == 3) PREADY = 1'b1;
    end
    @(negedge PCLK);
    n_cmp++;
    if (acc !== 4) begin
      n_bad++;
      $display("FAIL wait_access_cycles: got %0d, want 4", acc);
    end
    n_cmp++;
    if ({done1, err1, rdata1, state} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00}) begin
      n_bad++;
      $display("FAIL wait_read_done: got d1=%b e1=%b rd=%h st=%b, want 1 0 deadbeef 00",
               done1, err1, rdata1, state);
    end
    req1 = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_timeout;
    int acc = 0;
    PREADY = 1'b0;
    req0 = 1'b1; sel0 = 2'd1; write0 = 1'b0; addr0 = 5'h03;
    @(negedge PCLK);
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (state != 2'b10) break;
      acc++;
    end
    n_cmp++;
    if (acc !== 16) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d, want 16", acc);
    end
    n_cmp++;
    if ({done0, err0, rdata0, PSEL1, PSEL2, PENABLE, state} !==
        {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL timeout_abort: got d0=%b e0=%b rd=%h s1=%b s2=%b en=%b st=%b, want 1 1 0 0 0 0 00",
               done0, err0, rdata0, PSEL1, PSEL2, PENABLE, state);
    end
    req0 = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_invalid_sel;
    req1 = 1'b1; sel1 = 2'd0; write1 = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if ({state, PSEL1, PSEL2, PENABLE} !== {2'b11, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL badsel_err_state: got st=%b s1=%b s2=%b en=%b, want 11 0 0 0",
               state, PSEL1, PSEL2, PENABLE);
    end
    @(negedge PCLK);
    n_cmp++;
    if ({done1, err1, rdata1, state} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      n_bad++;
      $display("FAIL badsel_done: got d1=%b e1=%b rd=%h st=%b, want 1 1 deadbeef 00",
               done1, err1, rdata1, state);
    end
    req1 = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL badsel_single_pulse: got d1=%b, want 0", done1);
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    PREADY = 1'b0;
    req0 = 1'b1; sel0 = 2'd2; write0 = 1'b1; addr0 = 5'h07; wdata0 = 32'h77;
    @(negedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({state, PENABLE, PSEL2} !== {2'b10, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_in_access: got st=%b en=%b s2=%b, want 10 1 1", state, PENABLE, PSEL2);
    end
    #2 PRESETn = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL midrst_immediate: got %h, want 0", all_out);
    end
    req0 = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (done0 || done1 || state != 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_no_done: got activity=%b, want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    PRESETn = 1'b0; PREADY = 1'b0; PRDATA = '0;
    req0 = 1'b0; sel0 = '0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; sel1 = '0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset;
    test_write;
    test_round_robin;
    test_read_wait;
    test_timeout;
    test_invalid_sel;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
